// File: rtl/imem_loader.sv
// imem_loader
// Boot-time writer for the CPU's 256 x 16-bit instruction memory.
// The loader receives a byte stream over a valid/ready handshake. The first
// byte gives the program length in words, with 0 meaning 256 words. Each
// following pair of bytes forms one instruction word, high byte first. Words
// are written to consecutive addresses starting at 0. The CPU is held in reset
// until the last word has been written.
//
// Ports:
//   clk          - system clock, rising edge
//   reset        - asynchronous, active-low reset
//   start        - single-cycle load request, honoured only in IDLE or DONE
//   in_valid     - stream byte valid
//   in_data      - stream byte
//   in_ready     - loader accepts a byte on this cycle's rising edge
//   wr_en        - instruction memory write strobe, one cycle per word
//   wr_addr      - instruction memory write address
//   wr_data      - instruction word to write
//   cpu_reset    - active-high CPU hold while unloaded or loading
//   busy         - load in progress
//   done         - load complete, program valid
//   words_loaded - number of words written in the current or last load
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        HI,
        LO,
        WRITE,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] word_index;
    logic [ADDR_W:0]   word_count;
    logic [7:0]        hi_byte;

    // A byte transfers only on an edge where both sides agree.
    logic accept;
    assign accept = in_valid && in_ready;

    // Every output is a register. in_ready is therefore set on the same edge
    // that enters a receive state, so the handshake lines up with the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            in_ready     <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            cpu_reset    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            words_loaded <= '0;
            word_index   <= '0;
            word_count   <= '0;
            hi_byte      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= LEN;
                        in_ready     <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        cpu_reset    <= 1'b1;
                        words_loaded <= '0;
                        word_index   <= '0;
                    end
                end

                LEN: begin
                    if (accept) begin
                        // A length byte of zero encodes a full 256-word image.
                        if (in_data == 8'd0) begin
                            word_count <= {1'b1, {ADDR_W{1'b0}}};
                        end else begin
                            word_count <= (ADDR_W + 1)'(in_data);
                        end
                        state <= HI;
                    end
                end

                HI: begin
                    if (accept) begin
                        hi_byte <= in_data;
                        state   <= LO;
                    end
                end

                LO: begin
                    if (accept) begin
                        wr_data  <= DATA_W'({hi_byte, in_data});
                        wr_addr  <= word_index;
                        wr_en    <= 1'b1;
                        in_ready <= 1'b0;
                        state    <= WRITE;
                    end
                end

                WRITE: begin
                    // The index wraps to 0 after write 255. That case is also
                    // the terminating count, so the wrapped value is never used.
                    wr_en        <= 1'b0;
                    word_index   <= word_index + 1'b1;
                    words_loaded <= words_loaded + 1'b1;
                    if ((words_loaded + 1'b1) == word_count) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cpu_reset <= 1'b0;
                    end else begin
                        state    <= HI;
                        in_ready <= 1'b1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    wr_en    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Self-checking bench for imem_loader. A per-cycle vector table covers the
// basic two-word load. Hand-written sequences cover the stalled stream, the
// full 256-word image, reset during a load, and the restart rules.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic [8:0]  words_loaded;

    int n_checks = 0;
    int n_pass   = 0;

    // Each captured write is stored as {address, data}.
    logic [23:0] wq[$];

    imem_loader #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // wr_en lasts exactly one cycle, so sampling on the falling edge records
    // each write once.
    always @(negedge clk) begin
        if (wr_en) wq.push_back({wr_addr, wr_data});
    end

    typedef struct {
        string       name;
        logic        start;
        logic        in_valid;
        logic [7:0]  in_data;
        logic [37:0] expected;
    } vec_t;

    function automatic logic [37:0] pack_outs(input logic ir, input logic we,
                                              input logic [7:0] a, input logic [15:0] d,
                                              input logic b, input logic dn,
                                              input logic cr, input logic [8:0] wl);
        return {ir, we, a, d, b, dn, cr, wl};
    endfunction

    function automatic vec_t mk(input string n, input logic s, input logic v,
                                input logic [7:0] d, input logic [37:0] e);
        vec_t r;
        r.name     = n;
        r.start    = s;
        r.in_valid = v;
        r.in_data  = d;
        r.expected = e;
        return r;
    endfunction

    function automatic logic [37:0] dut_outs();
        return pack_outs(in_ready, wr_en, wr_addr, wr_data, busy, done, cpu_reset, words_loaded);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one vector's inputs and advances to just after the next rising edge.
    task automatic applyStimulus(input vec_t v);
        start    = v.start;
        in_valid = v.in_valid;
        in_data  = v.in_data;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Presents a byte until it is accepted, then drops in_valid for gap cycles.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int   t;
        logic acc;
        t        = 0;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        while (!acc && t < 50) begin
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            $display("[TB] FAIL send_byte timeout: byte 0x%0h not accepted, expected acceptance within 50 cycles", b);
        end
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (!done && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        checkOutput(name, 64'(done), 64'd1);
    endtask

    vec_t vecs[9];
    logic [7:0] lo_b;
    int bad_words;

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        vecs[0] = mk("start_with_valid", 1, 1, 8'h02, pack_outs(1, 0, 8'h00, 16'h0000, 1, 0, 1, 9'd0));
        vecs[1] = mk("len_accept",       0, 1, 8'h02, pack_outs(1, 0, 8'h00, 16'h0000, 1, 0, 1, 9'd0));
        vecs[2] = mk("hi0_accept",       0, 1, 8'h12, pack_outs(1, 0, 8'h00, 16'h0000, 1, 0, 1, 9'd0));
        vecs[3] = mk("lo0_write",        0, 1, 8'h34, pack_outs(0, 1, 8'h00, 16'h1234, 1, 0, 1, 9'd0));
        vecs[4] = mk("hold_in_write",    0, 1, 8'hAB, pack_outs(1, 0, 8'h00, 16'h1234, 1, 0, 1, 9'd1));
        vecs[5] = mk("hi1_accept",       0, 1, 8'hAB, pack_outs(1, 0, 8'h00, 16'h1234, 1, 0, 1, 9'd1));
        vecs[6] = mk("lo1_write",        0, 1, 8'hCD, pack_outs(0, 1, 8'h01, 16'hABCD, 1, 0, 1, 9'd1));
        vecs[7] = mk("done_entry",       0, 0, 8'h00, pack_outs(0, 0, 8'h01, 16'hABCD, 0, 1, 0, 9'd2));
        vecs[8] = mk("done_hold",        0, 0, 8'h00, pack_outs(0, 0, 8'h01, 16'hABCD, 0, 1, 0, 9'd2));

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", 64'(dut_outs()), 64'(pack_outs(0, 0, 8'h00, 16'h0000, 0, 0, 1, 9'd0)));
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Basic load, cycle by cycle.
        $display("[TB] basic load vectors");
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i].name, 64'(dut_outs()), 64'(vecs[i].expected));
        end
        checkOutput("basic_write_count", 64'(wq.size()), 64'd2);

        // Stalled stream: gaps between bytes. The HI byte after each LO byte
        // is presented while the loader is in WRITE.
        $display("[TB] stalled stream");
        wq.delete();
        pulse_start();
        send_byte(8'h02, 2);
        send_byte(8'h12, 1);
        send_byte(8'h34, 0);
        send_byte(8'hAB, 3);
        send_byte(8'hCD, 2);
        wait_done("stall_done");
        checkOutput("stall_write_count", 64'(wq.size()), 64'd2);
        if (wq.size() == 2) begin
            checkOutput("stall_write0", 64'(wq[0]), 64'h00_1234);
            checkOutput("stall_write1", 64'(wq[1]), 64'h01_ABCD);
        end
        checkOutput("stall_words_loaded", 64'(words_loaded), 64'd2);

        // Full memory: a length byte of 0 means 256 words.
        $display("[TB] full memory load");
        wq.delete();
        pulse_start();
        send_byte(8'h00, 0);
        for (int i = 0; i < 256; i++) begin
            lo_b = ~8'(i);
            send_byte(8'(i), 0);
            send_byte(lo_b, 0);
        end
        wait_done("full_done");
        checkOutput("full_write_count", 64'(wq.size()), 64'd256);
        bad_words = 0;
        foreach (wq[i]) begin
            lo_b = ~8'(i);
            if (wq[i] !== {8'(i), 8'(i), lo_b}) bad_words++;
        end
        checkOutput("full_bad_words", 64'(bad_words), 64'd0);
        if (wq.size() > 0) checkOutput("full_last_write", 64'(wq[wq.size()-1]), 64'hFF_FF00);
        checkOutput("full_words_loaded", 64'(words_loaded), 64'd256);
        checkOutput("full_cpu_reset", 64'(cpu_reset), 64'd0);

        // Reset after the HI byte of word 1 in a three-word load.
        $display("[TB] reset mid-load");
        wq.delete();
        pulse_start();
        send_byte(8'h03, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        reset = 1'b0;
        #1;
        checkOutput("midreset_outputs", 64'(dut_outs()), 64'(pack_outs(0, 0, 8'h00, 16'h0000, 0, 0, 1, 9'd0)));
        repeat (2) @(posedge clk);
        #1;
        checkOutput("midreset_write_count", 64'(wq.size()), 64'd1);
        if (wq.size() == 1) checkOutput("midreset_write0", 64'(wq[0]), 64'h00_1122);
        reset = 1'b1;
        @(posedge clk);
        #1;
        wq.delete();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h55, 0);
        send_byte(8'hAA, 0);
        wait_done("after_reset_done");
        checkOutput("after_reset_write_count", 64'(wq.size()), 64'd1);
        if (wq.size() == 1) checkOutput("after_reset_write0", 64'(wq[0]), 64'h00_55AA);

        // A start pulse during LO is ignored. A start after DONE begins a new load.
        $display("[TB] restart rules");
        wq.delete();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        pulse_start();
        checkOutput("start_in_lo_busy_ready", 64'({busy, in_ready, done, wr_en}), 64'b1100);
        send_byte(8'h04, 0);
        wait_done("restart_first_done");
        checkOutput("restart_first_writes", 64'(wq.size()), 64'd2);
        if (wq.size() == 2) checkOutput("restart_first_write1", 64'(wq[1]), 64'h01_0304);
        wq.delete();
        pulse_start();
        checkOutput("restart_flags", 64'({in_ready, busy, done, cpu_reset, words_loaded}), 64'({4'b1101, 9'd0}));
        send_byte(8'h01, 0);
        send_byte(8'h77, 0);
        send_byte(8'h88, 0);
        wait_done("restart_second_done");
        checkOutput("restart_second_writes", 64'(wq.size()), 64'd1);
        if (wq.size() == 1) checkOutput("restart_second_write0", 64'(wq[0]), 64'h00_7788);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
